// File: rtl/myiic_byte_master.sv
// I2C byte-level master engine.
// Each accepted command runs one 8-bit write or read on the bus. A START or
// repeated START can precede the byte, and a STOP can follow it. A byte that
// ends without STOP parks the bus with SCL low, so the next command can carry on
// without a new START. Every phase lasts exactly HALF clk cycles. All pin
// outputs are registered and change when a phase is entered.
module myiic_byte_master #(
    parameter int HALF  = 5,   // clk cycles per phase (>= 2)
    parameter int CNT_W = 8    // phase counter width, must hold HALF-1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_nack,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_ack_err,
    output logic       busy,
    output logic       bus_held,
    output logic       scl,
    inout  wire        sda,
    output logic       sda_dir
);

    typedef enum logic [3:0] {
        IDLE,   // bus free, SCL high, SDA released
        S0,     // START: release SDA, SCL untouched
        S1,     // START: raise SCL
        S2,     // START: pull SDA low while SCL high
        BIT_L,  // data bit, SCL low, SDA set up
        BIT_H,  // data bit, SCL high
        ACK_L,  // acknowledge bit, SCL low
        ACK_H,  // acknowledge bit, SCL high
        P0,     // STOP: SCL low, SDA low
        P1,     // STOP: raise SCL
        P2,     // STOP: release SDA while SCL high
        PARK    // byte done without STOP, SCL parked low
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_reg;
    logic [7:0]       data_reg;
    logic             op_read_reg;
    logic             op_stop_reg;
    logic             op_nack_reg;
    logic             ack_err_reg;
    logic             phase_end;
    logic             wait_state;
    logic             sda_in;

    // Open-drain pad: the master only ever pulls low.
    assign sda        = sda_dir ? 1'b0 : 1'bz;
    assign sda_in     = sda;
    assign phase_end  = (cnt_reg == CNT_W'(HALF - 1));
    assign wait_state = (state_reg == IDLE) || (state_reg == PARK);

    // Phase sequencer: command accept, pin drive, bit shifting and response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            data_reg    <= '0;
            op_read_reg <= 1'b0;
            op_stop_reg <= 1'b0;
            op_nack_reg <= 1'b0;
            ack_err_reg <= 1'b0;
            scl         <= 1'b1;
            sda_dir     <= 1'b0;
            busy        <= 1'b0;
            bus_held    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'h00;
            rsp_ack_err <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            // busy covers the response cycle and drops on the cycle after it.
            if (rsp_valid) begin
                busy <= 1'b0;
            end
            // The counter idles at zero so the first phase after accept is full length.
            if (wait_state || phase_end) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            case (state_reg)
                IDLE, PARK: begin
                    if (cmd_valid) begin
                        op_read_reg <= cmd_read;
                        op_stop_reg <= cmd_stop;
                        op_nack_reg <= cmd_nack;
                        data_reg    <= cmd_wdata;
                        bit_reg     <= 3'd7;
                        busy        <= 1'b1;
                        cmd_ready   <= 1'b0;
                        // A free bus always needs a START, whatever the command says.
                        if (cmd_start || !bus_held) begin
                            state_reg <= S0;
                            sda_dir   <= 1'b0;
                        end else begin
                            state_reg <= BIT_L;
                            scl       <= 1'b0;
                            sda_dir   <= ~cmd_read & ~cmd_wdata[7];
                        end
                    end
                end
                S0: begin
                    if (phase_end) begin
                        state_reg <= S1;
                        scl       <= 1'b1;
                    end
                end
                S1: begin
                    if (phase_end) begin
                        state_reg <= S2;
                        sda_dir   <= 1'b1;
                    end
                end
                S2: begin
                    if (phase_end) begin
                        state_reg <= BIT_L;
                        scl       <= 1'b0;
                        sda_dir   <= ~op_read_reg & ~data_reg[7];
                    end
                end
                BIT_L: begin
                    if (phase_end) begin
                        state_reg <= BIT_H;
                        scl       <= 1'b1;
                    end
                end
                BIT_H: begin
                    if (phase_end) begin
                        // Shift register sends MSB first and collects read bits at the LSB.
                        data_reg <= {data_reg[6:0], sda_in};
                        scl      <= 1'b0;
                        if (bit_reg == 3'd0) begin
                            state_reg <= ACK_L;
                            sda_dir   <= op_read_reg & ~op_nack_reg;
                        end else begin
                            state_reg <= BIT_L;
                            bit_reg   <= bit_reg - 1'b1;
                            // data_reg shifts on this same edge, so the next bit is [6].
                            sda_dir   <= ~op_read_reg & ~data_reg[6];
                        end
                    end
                end
                ACK_L: begin
                    if (phase_end) begin
                        state_reg <= ACK_H;
                        scl       <= 1'b1;
                    end
                end
                ACK_H: begin
                    if (phase_end) begin
                        ack_err_reg <= ~op_read_reg & sda_in;
                        scl         <= 1'b0;
                        if (op_stop_reg) begin
                            state_reg <= P0;
                            sda_dir   <= 1'b1;
                        end else begin
                            state_reg   <= PARK;
                            sda_dir     <= 1'b0;
                            bus_held    <= 1'b1;
                            cmd_ready   <= 1'b1;
                            rsp_valid   <= 1'b1;
                            rsp_ack_err <= ~op_read_reg & sda_in;
                            if (op_read_reg) begin
                                rsp_rdata <= data_reg;
                            end
                        end
                    end
                end
                P0: begin
                    if (phase_end) begin
                        state_reg <= P1;
                        scl       <= 1'b1;
                    end
                end
                P1: begin
                    if (phase_end) begin
                        state_reg <= P2;
                        sda_dir   <= 1'b0;
                    end
                end
                P2: begin
                    if (phase_end) begin
                        state_reg   <= IDLE;
                        bus_held    <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_ack_err <= ack_err_reg;
                        if (op_read_reg) begin
                            rsp_rdata <= data_reg;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    scl       <= 1'b1;
                    sda_dir   <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_myiic_byte_master.sv
// Directed bench for myiic_byte_master (HALF=5). A small reactive slave on the
// bus ACKs writes or shifts out a byte on reads. A bus monitor records the SDA
// value at every SCL rise, START conditions, and response pulses.
module tb_myiic_byte_master;

    logic       clk       = 1'b0;
    logic       rstn      = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_start = 1'b0;
    logic       cmd_stop  = 1'b0;
    logic       cmd_read  = 1'b0;
    logic       cmd_nack  = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_ack_err;
    logic       busy;
    logic       bus_held;
    logic       scl;
    logic       sda_dir;
    wire        sda_bus;

    // slave_mode: 0 passive, 1 ACK writes, 2 transmit slave_byte
    int         slave_mode = 0;
    logic [7:0] slave_byte = 8'h00;
    logic       slave_low  = 1'b0;

    logic        scl_prev  = 1'b1;
    logic        sda_prev  = 1'b1;
    int          fall_cnt  = 0;
    int          mon_c     = 0;
    logic [15:0] rise_bits = 16'h0000;
    int          rise_cnt  = 0;
    int          start_cnt = 0;
    int          dir_cnt   = 0;
    int          rv_cnt    = 0;

    int tests = 0;
    int fails = 0;

    assign sda_bus = slave_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    myiic_byte_master #(.HALF(5), .CNT_W(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_start   (cmd_start),
        .cmd_stop    (cmd_stop),
        .cmd_read    (cmd_read),
        .cmd_nack    (cmd_nack),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_ack_err (rsp_ack_err),
        .busy        (busy),
        .bus_held    (bus_held),
        .scl         (scl),
        .sda         (sda_bus),
        .sda_dir     (sda_dir)
    );

    // Slave and bus monitor. It samples on the falling clk edge, away from DUT updates.
    always @(negedge clk) begin
        mon_c = fall_cnt;
        if (scl && scl_prev && sda_prev && !sda_bus) begin
            mon_c = 0;
            start_cnt <= start_cnt + 1;
        end
        if (!scl && scl_prev) begin
            mon_c = mon_c + 1;
            case (slave_mode)
                1:       slave_low <= (mon_c == 9);
                2:       slave_low <= (mon_c >= 1 && mon_c <= 8) ? ~slave_byte[3'(8 - mon_c)] : 1'b0;
                default: slave_low <= 1'b0;
            endcase
        end
        if (scl && !scl_prev) begin
            rise_bits <= {rise_bits[14:0], sda_bus};
            rise_cnt  <= rise_cnt + 1;
        end
        if (sda_dir && mon_c >= 1 && mon_c <= 9) begin
            dir_cnt <= dir_cnt + 1;
        end
        if (rsp_valid) begin
            rv_cnt <= rv_cnt + 1;
        end
        fall_cnt <= mon_c;
        scl_prev <= scl;
        sda_prev <= sda_bus;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, wait for its response, and check latency, handshake and the SCL-high SDA trace.
    task automatic txn(input string name, input logic st, input logic sp, input logic rd,
                       input logic nk, input logic [7:0] wd, input int pulse_at,
                       input int exp_lat, input int exp_rises, input logic [15:0] exp_bits);
        int          lat;
        int          r0;
        int          v0;
        logic [15:0] mask;
        r0 = rise_cnt;
        v0 = rv_cnt;
        @(negedge clk);
        chk({name, "_ready_in"}, 32'(cmd_ready), 32'd1);
        cmd_start = st;
        cmd_stop  = sp;
        cmd_read  = rd;
        cmd_nack  = nk;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
            if (pulse_at != 0 && lat == pulse_at) begin
                chk({name, "_ready_busy"}, 32'(cmd_ready), 32'd0);
                cmd_valid = 1'b1;
                cmd_read  = ~rd;
                cmd_stop  = ~sp;
                cmd_wdata = ~wd;
            end else begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_busy_rsp"}, 32'(busy), 32'd1);
        chk({name, "_ready_rsp"}, 32'(cmd_ready), 32'd1);
        mask = 16'((32'd1 << exp_rises) - 32'd1);
        chk({name, "_rises"}, 32'(rise_cnt - r0), 32'(exp_rises));
        chk({name, "_sda_bits"}, 32'(rise_bits & mask), 32'(exp_bits));
        $display("[TB] %s: latency %0d, ack_err %0b, rdata 0x%02h", name, lat, rsp_ack_err, rsp_rdata);
        @(negedge clk);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_rsp_pulses"}, 32'(rv_cnt - v0), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int d0;
        int v0;

        // Reset state
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda_dir", 32'(sda_dir), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_held", 32'(bus_held), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'h00);
        chk("rst_ack_err", 32'(rsp_ack_err), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        $display("[TB] reset: scl %0b sda_dir %0b ready %0b", scl, sda_dir, cmd_ready);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0xA5 with START and STOP, slave ACKs
        slave_mode = 1;
        txn("wr_a5", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 0, 120, 10, 16'({8'hA5, 1'b0, 1'b0}));
        chk("wr_a5_ack_err", 32'(rsp_ack_err), 32'd0);
        chk("wr_a5_bus_held", 32'(bus_held), 32'd0);
        chk("wr_a5_scl_idle", 32'(scl), 32'd1);
        chk("wr_a5_sda_idle", 32'(sda_dir), 32'd0);

        // Write 0x3C with no slave: NACK reported, STOP still generated
        slave_mode = 0;
        txn("wr_3c_nack", 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 0, 120, 10, 16'({8'h3C, 1'b1, 1'b0}));
        chk("wr_3c_ack_err", 32'(rsp_ack_err), 32'd1);
        chk("wr_3c_bus_held", 32'(bus_held), 32'd0);
        chk("wr_3c_scl_idle", 32'(scl), 32'd1);

        // Read 0x96, master NACKs, master never drives during bits and ACK
        slave_mode = 2;
        slave_byte = 8'h96;
        d0 = dir_cnt;
        txn("rd_96", 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 0, 120, 10, 16'({8'h96, 1'b1, 1'b0}));
        chk("rd_96_rdata", 32'(rsp_rdata), 32'h96);
        chk("rd_96_ack_err", 32'(rsp_ack_err), 32'd0);
        chk("rd_96_sda_dir_in_byte", 32'(dir_cnt - d0), 32'd0);

        // cmd_start=0 on a free bus still produces a START
        slave_mode = 1;
        s0 = start_cnt;
        txn("wr_01_forced_start", 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 0, 120, 10, 16'({8'h01, 1'b0, 1'b0}));
        chk("wr_01_starts", 32'(start_cnt - s0), 32'd1);
        chk("wr_01_rdata_held", 32'(rsp_rdata), 32'h96);

        // Write without STOP parks the bus, then read with repeated START
        txn("wr_5a_park", 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 0, 105, 9, 16'({8'h5A, 1'b0}));
        chk("park_bus_held", 32'(bus_held), 32'd1);
        chk("park_scl", 32'(scl), 32'd0);
        chk("park_sda_dir", 32'(sda_dir), 32'd0);
        chk("park_ack_err", 32'(rsp_ack_err), 32'd0);
        slave_mode = 2;
        slave_byte = 8'hC3;
        s0 = start_cnt;
        txn("rd_c3_rstart", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 120, 11, 16'({1'b1, 8'hC3, 1'b0, 1'b0}));
        chk("rd_c3_rstart_seen", 32'(start_cnt - s0), 32'd1);
        chk("rd_c3_rdata", 32'(rsp_rdata), 32'hC3);
        chk("rd_c3_bus_held", 32'(bus_held), 32'd0);
        chk("rd_c3_scl_idle", 32'(scl), 32'd1);

        // From PARK with cmd_start=0 the START is skipped, passive slave gives NACK
        slave_mode = 1;
        txn("wr_5a_park2", 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 0, 105, 9, 16'({8'h5A, 1'b0}));
        slave_mode = 0;
        s0 = start_cnt;
        txn("wr_f0_skip", 1'b0, 1'b1, 1'b0, 1'b0, 8'hF0, 0, 105, 10, 16'({8'hF0, 1'b1, 1'b0}));
        chk("wr_f0_starts", 32'(start_cnt - s0), 32'd0);
        chk("wr_f0_ack_err", 32'(rsp_ack_err), 32'd1);
        chk("wr_f0_bus_held", 32'(bus_held), 32'd0);

        // cmd_valid pulsed mid-byte is ignored
        slave_mode = 1;
        txn("wr_81_busy", 1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 30, 120, 10, 16'({8'h81, 1'b0, 1'b0}));
        chk("wr_81_ack_err", 32'(rsp_ack_err), 32'd0);
        chk("wr_81_rdata_held", 32'(rsp_rdata), 32'hC3);

        // Async reset in BIT_H of bit 7 aborts at once with no response
        slave_mode = 0;
        v0 = rv_cnt;
        @(negedge clk);
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        cmd_read  = 1'b0;
        cmd_nack  = 1'b0;
        cmd_wdata = 8'h00;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (22) @(negedge clk);
        chk("abort_pre_scl", 32'(scl), 32'd1);
        chk("abort_pre_sda_dir", 32'(sda_dir), 32'd1);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("abort_scl", 32'(scl), 32'd1);
        chk("abort_sda_dir", 32'(sda_dir), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_bus_held", 32'(bus_held), 32'd0);
        $display("[TB] abort: scl %0b sda_dir %0b busy %0b", scl, sda_dir, busy);
        @(negedge clk);
        rstn = 1'b1;
        repeat (150) @(negedge clk);
        chk("abort_no_rsp", 32'(rv_cnt - v0), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_idle_scl", 32'(scl), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
